// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read slave (AR + R) among NUM_MASTERS masters.
// Latency: 1 arbitration cycle in IDLE, AR muxed straight through in ADDR, one IDLE bubble after RLAST.
// Backpressure: no buffering; m_arready / s_rready of the granted master pass straight through the muxes.
// Ports: clk/rst; s_ar*/s_r* per-master (flattened AR fields, broadcast R data);
//        m_ar*/m_r* single slave; busy, grant_idx, err_len (sticky burst length mismatch).
module axi_rd_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        s_arvalid,
  output logic [NUM_MASTERS-1:0]        s_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MASTERS*8-1:0]      s_arlen,
  output logic [NUM_MASTERS-1:0]        s_rvalid,
  input  logic [NUM_MASTERS-1:0]        s_rready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [7:0]                    m_arlen,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  output logic                          busy,
  output logic [2:0]                    grant_idx,
  output logic                          err_len
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            gnt;
  logic [IW-1:0]            pick;
  logic                     pick_vld;
  logic [7:0]               beat_cnt;
  logic [7:0]               arlen_q;
  logic                     g_arvalid;
  logic [ADDR_W-1:0]        g_araddr;
  logic [7:0]               g_arlen;
  logic                     g_rready;
  logic [NUM_MASTERS-1:0]   g_onehot;
  logic                     ar_hs;
  logic                     r_hs;

  // Round-robin pick: among requesters, the one with the smallest rotated
  // distance from rr_ptr wins, which equals the first set bit searching up
  // from rr_ptr with wrap.
  always_comb begin
    int best;
    int d;
    pick     = '0;
    pick_vld = 1'b0;
    best     = NUM_MASTERS;
    d        = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_MASTERS;
      if (s_arvalid[i] && (d < best)) begin
        best     = d;
        pick     = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  // Fields of the currently granted master.
  always_comb begin
    g_arvalid = 1'b0;
    g_araddr  = '0;
    g_arlen   = '0;
    g_rready  = 1'b0;
    g_onehot  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt == IW'(i)) begin
        g_arvalid   = s_arvalid[i];
        g_araddr    = s_araddr[i*ADDR_W +: ADDR_W];
        g_arlen     = s_arlen[i*8 +: 8];
        g_rready    = s_rready[i];
        g_onehot[i] = 1'b1;
      end
    end
  end

  assign ar_hs = (state == ADDR) && g_arvalid && m_arready;
  // m_rready depends only on state and s_rready, so no m_rvalid -> m_rready path.
  assign r_hs  = (state == DATA) && m_rvalid && g_rready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_araddr  = g_araddr;
    m_arlen   = g_arlen;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = ADDR;
      end
      ADDR: begin
        m_arvalid = g_arvalid;
        s_arready = m_arready ? g_onehot : '0;
        // A master dropping arvalid here simply keeps us waiting in ADDR.
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        m_rready = g_rready;
        s_rvalid = m_rvalid ? g_onehot : '0;
        // The slave's rlast decides the burst end, even if the count disagrees.
        if (r_hs && m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      gnt      <= '0;
      beat_cnt <= '0;
      arlen_q  <= '0;
      err_len  <= 1'b0;
    end else begin
      if ((state == IDLE) && pick_vld) begin
        gnt      <= pick;
        beat_cnt <= '0;
      end
      if (ar_hs) arlen_q <= g_arlen;
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        // Mismatch either way: rlast early/late versus the latched arlen.
        if (m_rlast != (beat_cnt == arlen_q)) err_len <= 1'b1;
        if (m_rlast) rr_ptr <= (gnt == IW'(NUM_MASTERS - 1)) ? '0 : gnt + IW'(1);
      end
    end
  end

  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign busy      = (state != IDLE);
  assign grant_idx = 3'(gnt);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter with a behavioural slave and master drivers.
// Latency: expected grants and R beats are queued at issue time and popped as the DUT hands them over.
// Backpressure: master 3 rready can toggle every cycle; slave arready drops while a burst is in flight.
module tb_axi_rd_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NM*AW-1:0] s_araddr;
  logic [NM*8-1:0] s_arlen;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            m_arvalid, m_arready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_rvalid, m_rready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            busy;
  logic [2:0]      grant_idx;
  logic            err_len;

  axi_rd_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .busy(busy), .grant_idx(grant_idx), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] m; logic [31:0] addr; logic [7:0] len; } gexp_t;
  typedef struct packed { logic [2:0] m; logic [31:0] data; logic last; } bexp_t;

  gexp_t eg_q[$];
  bexp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-master request tables, consumed by the master driver.
  logic [31:0] addr_tab [NM][16];
  logic [7:0]  len_tab  [NM][16];
  int          head [NM];
  int          tail [NM];
  logic        tog3;
  int          early;
  int          beats_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NM-1:0] onehot(input int m);
    logic [NM-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic issue(input int m, input logic [31:0] a, input logic [7:0] l);
    addr_tab[m][tail[m]] = a;
    len_tab[m][tail[m]]  = l;
    tail[m]++;
  endtask

  task automatic expect_txn(input int m, input logic [31:0] a, input logic [7:0] l, input int last_at);
    gexp_t g;
    bexp_t b;
    g.m = 3'(m); g.addr = a; g.len = l;
    eg_q.push_back(g);
    for (int i = 0; i <= last_at; i++) begin
      b.m = 3'(m); b.data = a + 32'(i); b.last = (i == last_at);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic drained();
    logic d;
    d = 1'b1;
    for (int m = 0; m < NM; m++) if (head[m] != tail[m]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 2000 && !(eg_q.size() == 0 && exp_q.size() == 0 && busy == 1'b0 && drained())) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 64'(n < 2000), 1);
    @(posedge clk); #2;
  endtask

  // Master driver: arvalid while a request is queued; pop on handshake.
  logic [NM-1:0] m_hs;
  initial begin
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '1;
    forever begin
      @(negedge clk);
      m_hs = s_arvalid & s_arready;
      @(posedge clk); #1;
      for (int m = 0; m < NM; m++) begin
        if (m_hs[m] && head[m] < tail[m]) head[m]++;
        s_arvalid[m] = (head[m] < tail[m]);
        if (head[m] < tail[m]) begin
          s_araddr[m*AW +: AW] = addr_tab[m][head[m]];
          s_arlen[m*8 +: 8]    = len_tab[m][head[m]];
        end
      end
      s_rready[3] = tog3 ? ~s_rready[3] : 1'b1;
    end
  end

  // Behavioural slave: data = araddr + beat; rlast at arlen or at the injected early beat.
  logic        sl_busy, sl_ar_hs, sl_r_hs, sl_rst;
  logic [31:0] sl_addr, sl_a;
  logic [7:0]  sl_len, sl_l, sl_beat;
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    sl_busy = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = '0;
    forever begin
      @(negedge clk);
      sl_ar_hs = m_arvalid & m_arready;
      sl_r_hs  = m_rvalid & m_rready;
      sl_rst   = rst;
      sl_a     = m_araddr;
      sl_l     = m_arlen;
      @(posedge clk); #1;
      if (sl_rst) begin
        sl_busy = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
      end else begin
        if (sl_r_hs) begin
          if (m_rlast) begin
            sl_busy = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
          end else begin
            sl_beat = sl_beat + 8'd1;
            m_rdata = sl_addr + 32'(sl_beat);
            m_rlast = (sl_beat == sl_len) || (int'(sl_beat) == early);
          end
        end
        if (sl_ar_hs) begin
          sl_busy = 1'b1; sl_addr = sl_a; sl_len = sl_l; sl_beat = '0;
          m_rvalid = 1'b1; m_rdata = sl_a;
          m_rlast = (sl_l == 8'd0) || (early == 0);
        end
        m_arready = !sl_busy;
      end
    end
  end

  // Monitor: scoreboard pops plus per-cycle isolation of the granted master.
  logic  in_data = 1'b0;
  logic  after_last = 1'b0;
  int    cur_m = 0;
  gexp_t mg;
  bexp_t mb;
  always @(negedge clk) begin
    if (rst) begin
      in_data = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        check("bubble_busy", 64'(busy), 0);
        check("bubble_arvalid", 64'(m_arvalid), 0);
        after_last = 1'b0;
      end
      if (in_data) begin
        check("data_arready", 64'(s_arready), 0);
        check("data_rvalid_iso", 64'(s_rvalid & ~onehot(cur_m)), 0);
        check("data_m_rready", 64'(m_rready), 64'(s_rready[cur_m]));
      end else begin
        check("nodata_rvalid", 64'(s_rvalid), 0);
        check("nodata_m_rready", 64'(m_rready), 0);
        if (busy && eg_q.size() != 0)
          check("addr_arready_iso", 64'(s_arready & ~onehot(int'(eg_q[0].m))), 0);
      end
      if (m_arvalid && m_arready) begin
        check("ar_expected", 64'(eg_q.size() != 0), 1);
        if (eg_q.size() != 0) begin
          mg = eg_q.pop_front();
          check("grant_idx", 64'(grant_idx), 64'(mg.m));
          check("m_araddr", 64'(m_araddr), 64'(mg.addr));
          check("m_arlen", 64'(m_arlen), 64'(mg.len));
          check("s_arready_hs", 64'(s_arready), 64'(onehot(int'(mg.m))));
          cur_m = int'(mg.m);
          in_data = 1'b1;
        end
      end
      if (m_rvalid && m_rready) begin
        beats_seen++;
        check("r_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          check("r_route", 64'(s_rvalid), 64'(onehot(int'(mb.m))));
          check("r_data", 64'(s_rdata), 64'(mb.data));
          check("r_last", 64'(s_rlast), 64'(mb.last));
        end
        if (m_rlast) begin
          in_data = 1'b0;
          after_last = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; tog3 = 1'b0; early = -1;
    for (int m = 0; m < NM; m++) begin head[m] = 0; tail[m] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant_idx), 0);
    check("rst_err", 64'(err_len), 0);
    check("rst_arready", 64'(s_arready), 0);
    check("rst_rvalid", 64'(s_rvalid), 0);
    check("rst_m_arvalid", 64'(m_arvalid), 0);
    check("rst_m_rready", 64'(m_rready), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Single master 1, arlen 3: one arbitration cycle, then ADDR with grant 1.
    issue(1, 32'h100, 8'd3); expect_txn(1, 32'h100, 8'd3, 3);
    @(posedge clk); @(negedge clk);
    check("t1_arb_busy", 64'(busy), 0);
    @(posedge clk); @(negedge clk);
    check("t1_addr_busy", 64'(busy), 1);
    check("t1_addr_grant", 64'(grant_idx), 1);
    check("t1_addr_arvalid", 64'(m_arvalid), 1);
    check("t1_addr_araddr", 64'(m_araddr), 64'h100);
    @(posedge clk); #2;
    wait_idle("t1");
    check("t1_rr_ptr", 64'(dut.rr_ptr), 2);
    check("t1_err", 64'(err_len), 0);

    // Master 3 moves rr_ptr back to 0.
    issue(3, 32'h300, 8'd0); expect_txn(3, 32'h300, 8'd0, 0);
    wait_idle("t1b");

    // Masters 0 and 2 together from rr_ptr 0: 0 first, then 2.
    issue(0, 32'h1000, 8'd2); issue(2, 32'h2000, 8'd1);
    expect_txn(0, 32'h1000, 8'd2, 2); expect_txn(2, 32'h2000, 8'd1, 1);
    wait_idle("t2");

    issue(3, 32'h304, 8'd0); expect_txn(3, 32'h304, 8'd0, 0);
    wait_idle("t2b");

    // All four requesting continuously: 0,1,2,3,0,1.
    issue(0, 32'h4000, 8'd0); issue(0, 32'h4004, 8'd0);
    issue(1, 32'h4100, 8'd0); issue(1, 32'h4104, 8'd0);
    issue(2, 32'h4200, 8'd0); issue(3, 32'h4300, 8'd0);
    expect_txn(0, 32'h4000, 8'd0, 0); expect_txn(1, 32'h4100, 8'd0, 0);
    expect_txn(2, 32'h4200, 8'd0, 0); expect_txn(3, 32'h4300, 8'd0, 0);
    expect_txn(0, 32'h4004, 8'd0, 0); expect_txn(1, 32'h4104, 8'd0, 0);
    wait_idle("t3");

    // Master 3 arlen 7 with rready toggling.
    tog3 = 1'b1;
    base = beats_seen;
    issue(3, 32'h5000, 8'd7); expect_txn(3, 32'h5000, 8'd7, 7);
    wait_idle("t4");
    tog3 = 1'b0;
    check("t4_beats", 64'(beats_seen - base), 8);

    // Early rlast on beat 2 of arlen 3: sticky err_len, then a clean burst.
    early = 2;
    issue(0, 32'h6000, 8'd3); expect_txn(0, 32'h6000, 8'd3, 2);
    wait_idle("t5");
    check("t5_err_set", 64'(err_len), 1);
    early = -1;
    issue(1, 32'h6100, 8'd1); expect_txn(1, 32'h6100, 8'd1, 1);
    wait_idle("t5b");
    check("t5_err_sticky", 64'(err_len), 1);

    // Reset in the middle of a burst by master 2.
    base = beats_seen;
    issue(2, 32'h7000, 8'd3); expect_txn(2, 32'h7000, 8'd3, 3);
    n = 0;
    while (n < 500 && beats_seen < base + 2) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6_reach_beat2", 64'(n < 500), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int m = 0; m < NM; m++) head[m] = tail[m];
    eg_q.delete();
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    check("t6_busy", 64'(busy), 0);
    check("t6_grant", 64'(grant_idx), 0);
    check("t6_err", 64'(err_len), 0);
    check("t6_rvalid", 64'(s_rvalid), 0);
    check("t6_arready", 64'(s_arready), 0);
    check("t6_m_arvalid", 64'(m_arvalid), 0);
    check("t6_m_rready", 64'(m_rready), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // rr_ptr restarted at 0: master 1 beats master 3.
    issue(1, 32'h8100, 8'd0); issue(3, 32'h8300, 8'd1);
    expect_txn(1, 32'h8100, 8'd0, 0); expect_txn(3, 32'h8300, 8'd1, 1);
    wait_idle("t7");
    check("t7_err", 64'(err_len), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
